// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dcache_ctrl_if
// Purpose  : Bundles the CPU-side request bus, the word-wide memory bus and
//            the statistics outputs of the data-cache controller.
// Modports : slave  - the cache controller
//            master - the environment (CPU pipeline + memory)
// Signals  : rd_req/wr_req/addr/wr_data/wr_be  CPU request (held while miss)
//            rd_data/miss                      CPU response / stall
//            mem_req/mem_we/mem_addr/mem_wdata memory command
//            mem_ack/mem_rdata                 memory completion / refill data
//            hit_cnt/miss_cnt                  statistics
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface dcache_ctrl_if;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [31:0] rd_data;
   logic        miss;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   modport slave (
      input  rd_req, wr_req, addr, wr_data, wr_be, mem_ack, mem_rdata,
      output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata,
             hit_cnt, miss_cnt
   );

   modport master (
      output rd_req, wr_req, addr, wr_data, wr_be, mem_ack, mem_rdata,
      input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata,
             hit_cnt, miss_cnt
   );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate data-cache controller.
//            Hits complete combinationally in IDLE; misses stall the pipeline
//            (miss=1) while a dirty victim line is written back (WB) and the
//            new line is refilled word by word (FILL).
// Ports    : clk   - core clock
//            rst_n - asynchronous active-low reset
//            bus   - dcache_ctrl_if.slave (CPU, memory and statistics signals)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dcache_ctrl #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 4,
   parameter int TAG_ADDR_LEN  = 23
) (
   input  wire           clk,
   input  wire           rst_n,
   dcache_ctrl_if.slave  bus
);

   localparam int c_SETS  = 1 << SET_ADDR_LEN;
   localparam int c_WORDS = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2
   } state_t;

   state_t                              r_state, w_next;
   logic [c_SETS-1:0]                   r_valid;
   logic [c_SETS-1:0]                   r_dirty;
   logic [TAG_ADDR_LEN-1:0]             r_tag  [c_SETS];
   logic [31:0]                         r_data [c_WORDS];
   logic [LINE_ADDR_LEN-1:0]            r_cnt;
   logic [31:0]                         r_hit_cnt;
   logic [31:0]                         r_miss_cnt;
   logic [31:0]                         r_rd_data;

   logic [TAG_ADDR_LEN-1:0]             w_tag;
   logic [SET_ADDR_LEN-1:0]             w_set;
   logic [LINE_ADDR_LEN-1:0]            w_word;
   logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] w_idx;
   logic [SET_ADDR_LEN+LINE_ADDR_LEN-1:0] w_cnt_idx;
   logic                                w_req, w_hit, w_hit_acc, w_rd_hit, w_wr_hit;
   logic                                w_last;
   logic                                w_miss, w_mem_req, w_mem_we;
   logic [31:0]                         w_mem_addr, w_mem_wdata;
   logic [1:0]                          w_unused;

   assign w_tag     = bus.addr[31 -: TAG_ADDR_LEN];
   assign w_set     = bus.addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
   assign w_word    = bus.addr[LINE_ADDR_LEN+1:2];
   assign w_idx     = {w_set, w_word};
   assign w_cnt_idx = {w_set, r_cnt};
   assign w_unused  = bus.addr[1:0];

   assign w_req     = bus.rd_req | bus.wr_req;
   assign w_hit     = r_valid[w_set] & (r_tag[w_set] == w_tag);
   assign w_hit_acc = (r_state == S_IDLE) & w_req & w_hit;
   // A simultaneous read and write request is handled as a write.
   assign w_wr_hit  = w_hit_acc & bus.wr_req;
   assign w_rd_hit  = w_hit_acc & ~bus.wr_req;
   assign w_last    = bus.mem_ack & (&r_cnt);

   always_comb begin
      w_next      = r_state;
      w_miss      = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = 32'd0;
      w_mem_wdata = 32'd0;
      unique case (r_state)
         S_IDLE: begin
            if (w_req && !w_hit) begin
               w_miss = 1'b1;
               w_next = (r_valid[w_set] && r_dirty[w_set]) ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            w_miss      = 1'b1;
            w_mem_req   = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = {r_tag[w_set], w_set, r_cnt, 2'b00};
            w_mem_wdata = r_data[w_cnt_idx];
            if (w_last) begin
               w_next = S_FILL;
            end
         end
         S_FILL: begin
            w_miss     = 1'b1;
            w_mem_req  = 1'b1;
            w_mem_addr = {w_tag, w_set, r_cnt, 2'b00};
            if (w_last) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_dirty    <= '0;
         r_cnt      <= '0;
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
         r_rd_data  <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_hit_acc) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_rd_hit) begin
            r_rd_data <= r_data[w_idx];
         end
         if (w_wr_hit) begin
            r_dirty[w_set] <= 1'b1;
         end
         if ((r_state == S_IDLE) && w_miss) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_cnt      <= '0;
         end
         // Counter wraps to zero on the last word, ready for the next phase.
         if ((r_state != S_IDLE) && bus.mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if ((r_state == S_FILL) && w_last) begin
            r_valid[w_set] <= 1'b1;
            r_dirty[w_set] <= 1'b0;
         end
      end
   end

   // Data and tag storage carry no reset; validity is tracked by r_valid.
   always_ff @(posedge clk) begin
      if ((r_state == S_FILL) && bus.mem_ack) begin
         r_data[w_cnt_idx] <= bus.mem_rdata;
      end
      if ((r_state == S_FILL) && w_last) begin
         r_tag[w_set] <= w_tag;
      end
      if (w_wr_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wr_be[b]) begin
               r_data[w_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
            end
         end
      end
   end

   assign bus.rd_data   = w_rd_hit ? r_data[w_idx] : r_rd_data;
   assign bus.miss      = w_miss;
   assign bus.mem_req   = w_mem_req;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.hit_cnt   = r_hit_cnt;
   assign bus.miss_cnt  = r_miss_cnt;

endmodule
`default_nettype wire
